// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
// Drives the 4-LED display path. A 32-bit base prescaler and a 2-bit slow
// counter form the step timebase; on each step the LED pattern advances
// according to the selected mode (shift-left, shift-right, ping-pong, blink).
// Mode, speed and run/pause change on single-cycle debounced button pulses.
//
// Ports:
//   clock      board clock, rising edge
//   reset      asynchronous, active-high reset
//   mode_btn   one-cycle pulse: advance mode (reloads that mode's seed)
//   speed_btn  one-cycle pulse: advance speed level
//   run_btn    one-cycle pulse: toggle run/pause
//   led_out    registered LED drive
//   mode       current mode: 0 SHIFT_L, 1 SHIFT_R, 2 PINGPONG, 3 BLINK
//   speed      current speed level; step period = (CNT_MAX+1)*(speed+1)
//   running    1 = pattern advancing, 0 = paused
//   step       one-cycle pulse while led_out holds a freshly advanced value
// -----------------------------------------------------------------------------
module led_mode_sequencer #(
   parameter logic [31:0] CNT_MAX = 32'd100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       speed_btn,
   input  logic       run_btn,
   output logic [3:0] led_out,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       running,
   output logic       step
);

   typedef enum logic [1:0] {
      MODE_SHIFT_L  = 2'd0,
      MODE_SHIFT_R  = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_e;

   mode_e       mode_r;
   mode_e       mode_next_s;
   logic [3:0]  led_r;
   logic [1:0]  speed_r;
   logic        running_r;
   logic        step_r;
   logic        dir_left_r;
   logic [31:0] base_cnt_r;
   logic [1:0]  slow_cnt_r;

   logic        btn_any_s;
   logic        base_wrap_s;
   logic        slow_hit_s;
   logic [3:0]  adv_led_s;
   logic        adv_dir_left_s;
   logic        going_left_s;

   // Exactly one LED lit; anything else is a corrupted pattern.
   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   // Pattern a mode starts from when it is selected.
   function automatic logic [3:0] seed_for(input mode_e m);
      logic [3:0] s;
      case (m)
         MODE_SHIFT_L:  s = 4'b0001;
         MODE_SHIFT_R:  s = 4'b1000;
         MODE_PINGPONG: s = 4'b0001;
         MODE_BLINK:    s = 4'b1111;
         default:       s = 4'b0001;
      endcase
      return s;
   endfunction

   assign btn_any_s   = mode_btn | speed_btn | run_btn;
   assign base_wrap_s = (base_cnt_r == CNT_MAX);
   assign slow_hit_s  = (slow_cnt_r == speed_r);
   assign mode_next_s = mode_e'(mode_r + 2'd1);

   // Next pattern and ping-pong direction for a step in the current mode.
   always_comb begin
      adv_led_s      = led_r;
      adv_dir_left_s = dir_left_r;
      going_left_s   = dir_left_r;
      case (mode_r)
         MODE_SHIFT_L: begin
            if (is_one_hot(led_r)) adv_led_s = {led_r[2:0], led_r[3]};
            else                   adv_led_s = 4'b0001;
         end
         MODE_SHIFT_R: begin
            if (is_one_hot(led_r)) adv_led_s = {led_r[0], led_r[3:1]};
            else                   adv_led_s = 4'b1000;
         end
         MODE_PINGPONG: begin
            if (is_one_hot(led_r)) begin
               // The end LEDs force a turn even if the direction bit disagrees.
               going_left_s = (dir_left_r && (led_r != 4'b1000)) || (led_r == 4'b0001);
               if (going_left_s) adv_led_s = {led_r[2:0], 1'b0};
               else              adv_led_s = {1'b0, led_r[3:1]};
               if (adv_led_s == 4'b1000)      adv_dir_left_s = 1'b0;
               else if (adv_led_s == 4'b0001) adv_dir_left_s = 1'b1;
               else                           adv_dir_left_s = going_left_s;
            end else begin
               adv_led_s      = 4'b0001;
               adv_dir_left_s = 1'b1;
            end
         end
         MODE_BLINK: begin
            if (led_r == 4'b1111) adv_led_s = 4'b0000;
            else                  adv_led_s = 4'b1111;
         end
         default: begin
            adv_led_s      = 4'b0001;
            adv_dir_left_s = 1'b1;
         end
      endcase
   end

   // Timebase, button handling and pattern state; buttons override a coincident step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_r     <= MODE_SHIFT_L;
         led_r      <= 4'b0001;
         speed_r    <= 2'd0;
         running_r  <= 1'b1;
         step_r     <= 1'b0;
         dir_left_r <= 1'b1;
         base_cnt_r <= 32'd0;
         slow_cnt_r <= 2'd0;
      end else begin
         step_r <= 1'b0;
         if (btn_any_s) begin
            base_cnt_r <= 32'd0;
            slow_cnt_r <= 2'd0;
            if (mode_btn) begin
               mode_r     <= mode_next_s;
               led_r      <= seed_for(mode_next_s);
               dir_left_r <= 1'b1;
            end
            if (speed_btn) speed_r <= speed_r + 2'd1;
            if (run_btn)   running_r <= ~running_r;
         end else if (running_r) begin
            if (base_wrap_s) begin
               base_cnt_r <= 32'd0;
               if (slow_hit_s) begin
                  slow_cnt_r <= 2'd0;
                  led_r      <= adv_led_s;
                  dir_left_r <= adv_dir_left_s;
                  step_r     <= 1'b1;
               end else begin
                  slow_cnt_r <= slow_cnt_r + 2'd1;
               end
            end else begin
               base_cnt_r <= base_cnt_r + 32'd1;
            end
         end else begin
            base_cnt_r <= 32'd0;
            slow_cnt_r <= 2'd0;
         end
      end
   end

   assign led_out = led_r;
   assign mode    = mode_r;
   assign speed   = speed_r;
   assign running = running_r;
   assign step    = step_r;

endmodule
